// File: rtl/store_queue_pkg.sv
// Shared micro-architecture constants and types for the backend store queue.
// Holds the queue geometry, pipeline widths, the per-entry record and the
// state encodings used by both the queue proper and its drain controller.
// Ports: none (package).
package store_queue_pkg;

    localparam int SQ_ENTRIES    = 8;
    localparam int SQ_PTR_W      = $clog2(SQ_ENTRIES);
    localparam int PIPE_WIDTH    = 2;
    localparam int TAG_WIDTH     = 6;
    localparam int CPU_ADDR_BITS = 32;
    localparam int CPU_DATA_BITS = 32;
    localparam int CPU_MASK_BITS = CPU_DATA_BITS / 8;

    // Pointers carry one extra wrap bit above the slot index so that a full
    // queue (same index, different wrap) is distinguishable from an empty one.
    typedef logic [SQ_PTR_W:0]   sq_ptr_t;
    typedef logic [SQ_PTR_W-1:0] sq_idx_t;

    typedef enum logic [1:0] {
        SQ_FREE      = 2'd0,
        SQ_ALLOC     = 2'd1,
        SQ_READY     = 2'd2,
        SQ_COMMITTED = 2'd3
    } sq_state_e;

    typedef struct packed {
        sq_state_e                state;
        logic [TAG_WIDTH-1:0]     rob_tag;
        logic [CPU_ADDR_BITS-1:0] addr;
        logic [CPU_DATA_BITS-1:0] data;
        logic [CPU_MASK_BITS-1:0] mask;
    } sq_entry_t;

    typedef enum logic [1:0] {
        DR_IDLE     = 2'd0,
        DR_REQ      = 2'd1,
        DR_WAIT_ACK = 2'd2
    } sq_drain_state_e;

    function automatic sq_idx_t ptr_idx(input sq_ptr_t p);
        return p[SQ_PTR_W-1:0];
    endfunction

    function automatic sq_ptr_t ptr_bump(input sq_ptr_t p, input logic [1:0] n);
        return p + sq_ptr_t'(n);
    endfunction

    // Distance around the ring from slot 'from' to slot 'to', computed at
    // index width so the subtraction wraps modulo the queue depth.
    function automatic sq_ptr_t ring_dist(input sq_idx_t from, input sq_idx_t to);
        sq_idx_t d;
        d = to - from;
        return {1'b0, d};
    endfunction

endpackage

// File: rtl/sq_drain_ctrl.sv
// Drain controller for the store queue: watches the head entry and, once it is
// committed, issues exactly one write request to data memory, holds it until
// accepted, then waits for the write acknowledge before popping the head.
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   head_state          state of the entry at the queue head
//   head_addr/data/mask payload of the head entry
//   dmem_req_ready      memory accepts the request
//   dmem_resp_valid     memory acknowledges the write
//   dmem_req_valid      registered-state request valid
//   dmem_req_addr/data/mask registered request payload
//   head_pop            head entry retired this cycle
module sq_drain_ctrl
    import store_queue_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  sq_state_e                head_state,
    input  logic [CPU_ADDR_BITS-1:0] head_addr,
    input  logic [CPU_DATA_BITS-1:0] head_data,
    input  logic [CPU_MASK_BITS-1:0] head_mask,
    input  logic                     dmem_req_ready,
    input  logic                     dmem_resp_valid,
    output logic                     dmem_req_valid,
    output logic [CPU_ADDR_BITS-1:0] dmem_req_addr,
    output logic [CPU_DATA_BITS-1:0] dmem_req_data,
    output logic [CPU_MASK_BITS-1:0] dmem_req_mask,
    output logic                     head_pop
);

    sq_drain_state_e state;
    sq_drain_state_e state_n;

    // State register; reset drops any request in flight without waiting
    // for its acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= DR_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic: one outstanding store at a time. An acknowledge that
    // arrives outside WAIT_ACK has no effect.
    always_comb begin
        state_n = state;
        unique case (state)
            DR_IDLE:     if (head_state == SQ_COMMITTED) state_n = DR_REQ;
            DR_REQ:      if (dmem_req_ready)             state_n = DR_WAIT_ACK;
            DR_WAIT_ACK: if (dmem_resp_valid)            state_n = DR_IDLE;
            default:                                     state_n = DR_IDLE;
        endcase
    end

    // Outputs decoded from the registered state so valid is glitch-free and
    // stays asserted for as long as the request is pending.
    always_comb begin
        dmem_req_valid = (state == DR_REQ);
        head_pop       = (state == DR_WAIT_ACK) && dmem_resp_valid;
    end

    // Request payload is captured once when leaving IDLE and then held, so it
    // stays stable however long memory back-pressures the request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            dmem_req_addr <= '0;
            dmem_req_data <= '0;
            dmem_req_mask <= '0;
        end else if (state == DR_IDLE && head_state == SQ_COMMITTED) begin
            dmem_req_addr <= head_addr;
            dmem_req_data <= head_data;
            dmem_req_mask <= head_mask;
        end
    end

endmodule

// File: rtl/store_queue.sv
// Backend store queue. Allocates entries in program order at dispatch,
// captures address/data/mask when the store executes, marks entries committed
// as the ROB retires them, and drains committed stores in order to data
// memory through sq_drain_ctrl. A flush squashes only uncommitted entries.
// Ports:
//   clk, rst                 clock, synchronous active-low reset
//   flush                    squash all uncommitted entries
//   sq_alloc_req/tag/gnt     two-lane in-order allocation, same-cycle grant
//   st_exec_*                executed store result, matched by ROB tag
//   commit_store_id/vals     two-lane in-order commit from the ROB
//   dmem_req_*/dmem_resp_valid  write port to data memory
//   sq_count, sq_empty       occupancy
module store_queue
    import store_queue_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic [PIPE_WIDTH-1:0]    sq_alloc_req,
    input  logic [TAG_WIDTH-1:0]     sq_alloc_tag [PIPE_WIDTH],
    output logic [PIPE_WIDTH-1:0]    sq_alloc_gnt,
    input  logic                     st_exec_valid,
    input  logic [TAG_WIDTH-1:0]     st_exec_tag,
    input  logic [CPU_ADDR_BITS-1:0] st_exec_addr,
    input  logic [CPU_DATA_BITS-1:0] st_exec_data,
    input  logic [CPU_MASK_BITS-1:0] st_exec_mask,
    input  logic [TAG_WIDTH-1:0]     commit_store_id [PIPE_WIDTH],
    input  logic [PIPE_WIDTH-1:0]    commit_store_vals,
    output logic                     dmem_req_valid,
    input  logic                     dmem_req_ready,
    output logic [CPU_ADDR_BITS-1:0] dmem_req_addr,
    output logic [CPU_DATA_BITS-1:0] dmem_req_data,
    output logic [CPU_MASK_BITS-1:0] dmem_req_mask,
    input  logic                     dmem_resp_valid,
    output logic [SQ_PTR_W:0]        sq_count,
    output logic                     sq_empty
);

    sq_entry_t entries   [SQ_ENTRIES];
    sq_entry_t entries_n [SQ_ENTRIES];

    sq_ptr_t head, tail, cmt_ptr;
    sq_ptr_t head_n, tail_n, cmt_n;
    sq_ptr_t count, free_slots, spec_cnt;
    logic    full;

    sq_idx_t                 alloc_idx  [PIPE_WIDTH];
    logic                    exec_hit;
    sq_idx_t                 exec_idx;
    logic [PIPE_WIDTH-1:0]   commit_ok;
    sq_idx_t                 commit_idx [PIPE_WIDTH];
    logic [SQ_ENTRIES-1:0]   flush_kill;
    logic                    head_pop;
    sq_entry_t               head_entry;

    // Occupancy from the wrap-extended pointers; all grant decisions use the
    // start-of-cycle value, so a drain in the same cycle never frees space early.
    always_comb begin
        count      = tail - head;
        free_slots = sq_ptr_t'(SQ_ENTRIES) - count;
        full       = (ptr_idx(tail) == ptr_idx(head)) && (tail[SQ_PTR_W] != head[SQ_PTR_W]);
        sq_count   = count;
        sq_empty   = (count == '0);
    end

    // Allocation grants. Lane 1 needs two free slots only when lane 0 is also
    // asking, since granted lanes take consecutive tail slots in lane order.
    // Nothing is granted during reset or while the pipeline is being flushed.
    always_comb begin
        sq_alloc_gnt = '0;
        if (rst && !flush) begin
            sq_alloc_gnt[0] = sq_alloc_req[0] && !full;
            if (sq_alloc_req[0]) begin
                sq_alloc_gnt[1] = sq_alloc_req[1] && (free_slots >= sq_ptr_t'(2));
            end else begin
                sq_alloc_gnt[1] = sq_alloc_req[1] && !full;
            end
        end
        alloc_idx[0] = ptr_idx(tail);
        alloc_idx[1] = ptr_idx(ptr_bump(tail, {1'b0, sq_alloc_gnt[0]}));
    end

    // Execute CAM: the executed store's tag is looked up among entries still
    // waiting for their payload. Tags are unique, so the first hit is the hit.
    always_comb begin
        exec_hit = 1'b0;
        exec_idx = '0;
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            if (st_exec_valid && !exec_hit && entries[i].state == SQ_ALLOC &&
                entries[i].rob_tag == st_exec_tag) begin
                exec_hit = 1'b1;
                exec_idx = sq_idx_t'(i);
            end
        end
    end

    // In-order commit. Lane 0 must name the entry at cmt_ptr; lane 1 must name
    // the entry right after whatever lane 0 took. If lane 0 presents a store
    // that cannot commit, lane 1 is held back so commits never go out of order.
    always_comb begin
        sq_ptr_t p1;
        commit_ok     = '0;
        commit_idx[0] = ptr_idx(cmt_ptr);
        commit_ok[0]  = rst && commit_store_vals[0] && (cmt_ptr != tail) &&
                        entries[commit_idx[0]].state == SQ_READY &&
                        entries[commit_idx[0]].rob_tag == commit_store_id[0];
        p1            = ptr_bump(cmt_ptr, {1'b0, commit_ok[0]});
        commit_idx[1] = ptr_idx(p1);
        commit_ok[1]  = rst && commit_store_vals[1] &&
                        (!commit_store_vals[0] || commit_ok[0]) && (p1 != tail) &&
                        entries[commit_idx[1]].state == SQ_READY &&
                        entries[commit_idx[1]].rob_tag == commit_store_id[1];
        cmt_n         = ptr_bump(cmt_ptr, {1'b0, commit_ok[0]} + {1'b0, commit_ok[1]});
    end

    // Flush squashes the speculative window measured from the post-commit
    // pointer, so a store committing in the flush cycle is kept.
    always_comb begin
        spec_cnt   = tail - cmt_n;
        flush_kill = '0;
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            flush_kill[i] = flush && (ring_dist(ptr_idx(cmt_n), sq_idx_t'(i)) < spec_cnt);
        end
    end

    // Pointer updates. Flush pulls tail back to the commit point; otherwise
    // tail advances by the number of granted lanes.
    always_comb begin
        head_n = ptr_bump(head, {1'b0, head_pop});
        if (flush) begin
            tail_n = cmt_n;
        end else begin
            tail_n = ptr_bump(tail, {1'b0, sq_alloc_gnt[0]} + {1'b0, sq_alloc_gnt[1]});
        end
    end

    // Next entry contents. Later updates take priority so a flush wins over an
    // execute on the same squashed entry; alloc, drain and commit touch
    // disjoint slots by construction.
    always_comb begin
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            entries_n[i] = entries[i];
        end
        if (exec_hit) begin
            entries_n[exec_idx].state = SQ_READY;
            entries_n[exec_idx].addr  = st_exec_addr;
            entries_n[exec_idx].data  = st_exec_data;
            entries_n[exec_idx].mask  = st_exec_mask;
        end
        for (int k = 0; k < PIPE_WIDTH; k++) begin
            if (commit_ok[k]) begin
                entries_n[commit_idx[k]].state = SQ_COMMITTED;
            end
        end
        for (int i = 0; i < SQ_ENTRIES; i++) begin
            if (flush_kill[i]) begin
                entries_n[i].state = SQ_FREE;
            end
        end
        if (head_pop) begin
            entries_n[ptr_idx(head)].state = SQ_FREE;
        end
        for (int k = 0; k < PIPE_WIDTH; k++) begin
            if (sq_alloc_gnt[k]) begin
                entries_n[alloc_idx[k]].state   = SQ_ALLOC;
                entries_n[alloc_idx[k]].rob_tag = sq_alloc_tag[k];
            end
        end
    end

    // Entry array and pointer registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head    <= '0;
            tail    <= '0;
            cmt_ptr <= '0;
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                entries[i] <= '0;
            end
        end else begin
            head    <= head_n;
            tail    <= tail_n;
            cmt_ptr <= cmt_n;
            for (int i = 0; i < SQ_ENTRIES; i++) begin
                entries[i] <= entries_n[i];
            end
        end
    end

    // Protocol checks on the ROB-side interfaces: an executed store must find
    // its entry, and every presented commit must be the next in-order READY store.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (st_exec_valid) begin
                assert (exec_hit)
                    else $error("store_queue: executed store tag %0d has no ALLOC entry", st_exec_tag);
            end
            for (int k = 0; k < PIPE_WIDTH; k++) begin
                if (commit_store_vals[k]) begin
                    assert (commit_ok[k])
                        else $error("store_queue: illegal commit on lane %0d, tag %0d", k, commit_store_id[k]);
                end
            end
        end
    end

    assign head_entry = entries[ptr_idx(head)];

    sq_drain_ctrl u_drain (
        .clk             (clk),
        .rst             (rst),
        .head_state      (head_entry.state),
        .head_addr       (head_entry.addr),
        .head_data       (head_entry.data),
        .head_mask       (head_entry.mask),
        .dmem_req_ready  (dmem_req_ready),
        .dmem_resp_valid (dmem_resp_valid),
        .dmem_req_valid  (dmem_req_valid),
        .dmem_req_addr   (dmem_req_addr),
        .dmem_req_data   (dmem_req_data),
        .dmem_req_mask   (dmem_req_mask),
        .head_pop        (head_pop)
    );

endmodule

// File: tb/tb_store_queue.sv
// Directed, self-checking bench for store_queue. A scoreboard queue receives
// the expected memory write whenever a store is committed and is popped when
// the queue presents its write request to memory.
module tb_store_queue;

    logic        clk;
    logic        rst;
    logic        flush;
    logic [1:0]  sq_alloc_req;
    logic [5:0]  sq_alloc_tag [2];
    logic [1:0]  sq_alloc_gnt;
    logic        st_exec_valid;
    logic [5:0]  st_exec_tag;
    logic [31:0] st_exec_addr;
    logic [31:0] st_exec_data;
    logic [3:0]  st_exec_mask;
    logic [5:0]  commit_store_id [2];
    logic [1:0]  commit_store_vals;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_req_addr;
    logic [31:0] dmem_req_data;
    logic [3:0]  dmem_req_mask;
    logic        dmem_resp_valid;
    logic [3:0]  sq_count;
    logic        sq_empty;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  mask;
    } exp_write_t;

    exp_write_t  exp_q [$];
    logic [31:0] m_addr [64];
    logic [31:0] m_data [64];
    logic [3:0]  m_mask [64];

    int vectors     = 0;
    int miscompares = 0;

    store_queue dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .sq_alloc_req      (sq_alloc_req),
        .sq_alloc_tag      (sq_alloc_tag),
        .sq_alloc_gnt      (sq_alloc_gnt),
        .st_exec_valid     (st_exec_valid),
        .st_exec_tag       (st_exec_tag),
        .st_exec_addr      (st_exec_addr),
        .st_exec_data      (st_exec_data),
        .st_exec_mask      (st_exec_mask),
        .commit_store_id   (commit_store_id),
        .commit_store_vals (commit_store_vals),
        .dmem_req_valid    (dmem_req_valid),
        .dmem_req_ready    (dmem_req_ready),
        .dmem_req_addr     (dmem_req_addr),
        .dmem_req_data     (dmem_req_data),
        .dmem_req_mask     (dmem_req_mask),
        .dmem_resp_valid   (dmem_resp_valid),
        .sq_count          (sq_count),
        .sq_empty          (sq_empty)
    );

    // Free-running clock; all driving and sampling happens on the falling edge.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a step never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
            else begin
                miscompares++;
                $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
            end
    endtask

    // Advance to the next falling edge and drop all single-cycle pulses.
    task automatic applyStimulus();
        @(negedge clk);
        sq_alloc_req      = 2'b00;
        st_exec_valid     = 1'b0;
        commit_store_vals = 2'b00;
        flush             = 1'b0;
        dmem_resp_valid   = 1'b0;
    endtask

    task automatic allocStores(input logic [1:0] req, input logic [5:0] t0, input logic [5:0] t1,
                               input logic [1:0] exp_gnt);
        sq_alloc_req    = req;
        sq_alloc_tag[0] = t0;
        sq_alloc_tag[1] = t1;
        #1;
        checkOutput("alloc_gnt", 64'(sq_alloc_gnt), 64'(exp_gnt));
        applyStimulus();
    endtask

    task automatic execStore(input logic [5:0] tag, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] mask);
        m_addr[tag]   = addr;
        m_data[tag]   = data;
        m_mask[tag]   = mask;
        st_exec_valid = 1'b1;
        st_exec_tag   = tag;
        st_exec_addr  = addr;
        st_exec_data  = data;
        st_exec_mask  = mask;
        applyStimulus();
    endtask

    task automatic commitStores(input logic [1:0] vals, input logic [5:0] id0, input logic [5:0] id1);
        exp_write_t w;
        if (vals[0]) begin
            w.addr = m_addr[id0]; w.data = m_data[id0]; w.mask = m_mask[id0];
            exp_q.push_back(w);
        end
        if (vals[1]) begin
            w.addr = m_addr[id1]; w.data = m_data[id1]; w.mask = m_mask[id1];
            exp_q.push_back(w);
        end
        commit_store_vals  = vals;
        commit_store_id[0] = id0;
        commit_store_id[1] = id1;
        applyStimulus();
    endtask

    // Serve one memory write: wait (bounded) for the request, hold ready low
    // for ready_delay cycles checking the request stays put, handshake, then
    // acknowledge ack_delay cycles later and check the head moved by one.
    task automatic drainOne(input int ready_delay, input int ack_delay);
        exp_write_t  w;
        logic [3:0]  cnt_before;
        int          waited;
        waited = 0;
        while (dmem_req_valid !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("drain_req_seen", 64'(dmem_req_valid), 64'(1'b1));
        if (dmem_req_valid !== 1'b1) return;
        checkOutput("scoreboard_has_entry", 64'(exp_q.size() > 0), 64'(1'b1));
        if (exp_q.size() == 0) return;
        w = exp_q.pop_front();
        for (int c = 0; c <= ready_delay; c++) begin
            checkOutput("req_valid_held", 64'(dmem_req_valid), 64'(1'b1));
            checkOutput("req_addr",       64'(dmem_req_addr),  64'(w.addr));
            checkOutput("req_data",       64'(dmem_req_data),  64'(w.data));
            checkOutput("req_mask",       64'(dmem_req_mask),  64'(w.mask));
            if (c < ready_delay) @(negedge clk);
        end
        cnt_before     = sq_count;
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        checkOutput("req_dropped_after_handshake", 64'(dmem_req_valid), 64'(1'b0));
        for (int c = 1; c < ack_delay; c++) begin
            @(negedge clk);
            checkOutput("no_pop_before_ack", 64'(sq_count), 64'(cnt_before));
        end
        dmem_resp_valid = 1'b1;
        applyStimulus();
        checkOutput("head_pop_by_one", 64'(sq_count), 64'(cnt_before - 4'd1));
    endtask

    initial begin
        rst               = 1'b0;
        flush             = 1'b0;
        sq_alloc_req      = 2'b00;
        sq_alloc_tag[0]   = '0;
        sq_alloc_tag[1]   = '0;
        st_exec_valid     = 1'b0;
        st_exec_tag       = '0;
        st_exec_addr      = '0;
        st_exec_data      = '0;
        st_exec_mask      = '0;
        commit_store_id[0] = '0;
        commit_store_id[1] = '0;
        commit_store_vals = 2'b00;
        dmem_req_ready    = 1'b0;
        dmem_resp_valid   = 1'b0;

        // Reset state, including grants forced low while in reset.
        repeat (2) @(negedge clk);
        checkOutput("reset_req_valid", 64'(dmem_req_valid), 64'(1'b0));
        checkOutput("reset_count",     64'(sq_count),       64'(0));
        checkOutput("reset_empty",     64'(sq_empty),       64'(1'b1));
        sq_alloc_req = 2'b11;
        #1;
        checkOutput("reset_gnt_forced", 64'(sq_alloc_gnt), 64'(2'b00));
        sq_alloc_req = 2'b00;
        rst = 1'b1;
        applyStimulus();

        // Reset while a request is outstanding aborts it.
        $display("[TB] step 1: reset mid-drain");
        allocStores(2'b01, 6'd1, 6'd0, 2'b01);
        execStore(6'd1, 32'h0000_0040, 32'h1111_2222, 4'hF);
        commitStores(2'b01, 6'd1, 6'd0);
        repeat (2) @(negedge clk);
        checkOutput("drain_started", 64'(dmem_req_valid), 64'(1'b1));
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midreset_req_valid", 64'(dmem_req_valid), 64'(1'b0));
        checkOutput("midreset_count",     64'(sq_count),       64'(0));
        checkOutput("midreset_empty",     64'(sq_empty),       64'(1'b1));
        exp_q.delete();
        rst = 1'b1;
        applyStimulus();

        // Two-lane alloc, execute in order, dual commit, two ordered writes.
        $display("[TB] step 2: dual alloc and commit");
        allocStores(2'b11, 6'd3, 6'd4, 2'b11);
        execStore(6'd3, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        execStore(6'd4, 32'h0000_0104, 32'h1234_5678, 4'h3);
        dmem_resp_valid = 1'b1;
        applyStimulus();
        checkOutput("stray_ack_ignored", 64'(sq_count), 64'(2));
        commitStores(2'b11, 6'd3, 6'd4);
        drainOne(0, 1);
        drainOne(0, 2);
        checkOutput("dual_empty_after_acks", 64'(sq_empty), 64'(1'b1));

        // Full and nearly-full grant behaviour.
        $display("[TB] step 3: grant limits");
        for (int p = 0; p < 4; p++) begin
            allocStores(2'b11, 6'(10 + 2 * p), 6'(11 + 2 * p), 2'b11);
        end
        checkOutput("fill_count", 64'(sq_count), 64'(8));
        allocStores(2'b11, 6'd0, 6'd0, 2'b00);
        execStore(6'd10, 32'h0000_0200, 32'hA5A5_0001, 4'h1);
        commitStores(2'b01, 6'd10, 6'd0);
        drainOne(0, 1);
        allocStores(2'b11, 6'd18, 6'd19, 2'b01);
        execStore(6'd11, 32'h0000_0204, 32'hA5A5_0002, 4'h2);
        commitStores(2'b01, 6'd11, 6'd0);
        drainOne(1, 1);
        allocStores(2'b10, 6'd0, 6'd19, 2'b10);
        checkOutput("refill_count", 64'(sq_count), 64'(8));
        flush = 1'b1;
        applyStimulus();
        checkOutput("flush_all_speculative", 64'(sq_count), 64'(0));

        // Flush keeps committed stores and rewinds tail to the commit point.
        $display("[TB] step 4: flush with committed stores");
        allocStores(2'b11, 6'd20, 6'd21, 2'b11);
        allocStores(2'b11, 6'd22, 6'd23, 2'b11);
        allocStores(2'b01, 6'd24, 6'd0,  2'b01);
        execStore(6'd20, 32'h0000_0300, 32'hC0DE_0020, 4'hF);
        execStore(6'd21, 32'h0000_0304, 32'hC0DE_0021, 4'hC);
        execStore(6'd22, 32'h0000_0308, 32'hC0DE_0022, 4'h8);
        commitStores(2'b11, 6'd20, 6'd21);
        flush = 1'b1;
        applyStimulus();
        checkOutput("flush_keeps_committed", 64'(sq_count), 64'(2));
        allocStores(2'b01, 6'd25, 6'd0, 2'b01);
        execStore(6'd25, 32'h0000_030C, 32'hC0DE_0025, 4'h6);
        commitStores(2'b01, 6'd25, 6'd0);
        drainOne(0, 1);
        drainOne(0, 1);
        drainOne(0, 1);
        checkOutput("flush_empty_after_drain", 64'(sq_empty), 64'(1'b1));

        // Back-pressure: request held stable, late acknowledge pops one entry.
        $display("[TB] step 5: back-pressure and late ack");
        allocStores(2'b11, 6'd30, 6'd31, 2'b11);
        execStore(6'd30, 32'h0000_0400, 32'hCAFE_F00D, 4'h5);
        execStore(6'd31, 32'h0000_0404, 32'h0BAD_F00D, 4'hA);
        commitStores(2'b11, 6'd30, 6'd31);
        drainOne(10, 3);
        drainOne(0, 1);
        checkOutput("bp_empty", 64'(sq_empty), 64'(1'b1));

        // Twenty stores through eight slots, pointers wrapping repeatedly.
        $display("[TB] step 6: wrap-around traffic");
        for (int blk = 0; blk < 5; blk++) begin
            for (int p = 0; p < 2; p++) begin
                allocStores(2'b11, 6'(40 + 4 * blk + 2 * p), 6'(41 + 4 * blk + 2 * p), 2'b11);
            end
            checkOutput("wrap_count", 64'(sq_count), 64'(4));
            checkOutput("wrap_count_bound", 64'(sq_count <= 4'd8), 64'(1'b1));
            for (int j = 0; j < 4; j++) begin
                execStore(6'(40 + 4 * blk + j), 32'(32'h1000 + 4 * (40 + 4 * blk + j)),
                          32'($urandom), 4'($urandom_range(1, 15)));
            end
            commitStores(2'b11, 6'(40 + 4 * blk), 6'(41 + 4 * blk));
            commitStores(2'b11, 6'(42 + 4 * blk), 6'(43 + 4 * blk));
            for (int j = 0; j < 4; j++) begin
                drainOne(j % 3, 1 + (blk % 2));
            end
        end
        checkOutput("wrap_empty", 64'(sq_empty), 64'(1'b1));
        checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
